// File: rtl/quad_downmixer_pkg.sv
// Shared constants and LO lookup for the quadrature mixers.
// LO codes per rail: 01 = +1, 10 = -1, 00 = 0 (11 is never produced).
package quad_downmixer_pkg;

    localparam int SAMPLE_W = 15;

    typedef enum logic [1:0] {
        LO_ZERO = 2'b00,
        LO_POS  = 2'b01,
        LO_NEG  = 2'b10
    } lo_code_t;

    typedef struct packed {
        lo_code_t i;
        lo_code_t q;
    } lo_pair_t;

    // fs/4 LO: I = cos, Q = -sin
    function automatic lo_pair_t phase_lo(input logic [1:0] phase);
        lo_pair_t p;
        case (phase)
            2'd0:    begin p.i = LO_POS;  p.q = LO_ZERO; end
            2'd1:    begin p.i = LO_ZERO; p.q = LO_NEG;  end
            2'd2:    begin p.i = LO_NEG;  p.q = LO_ZERO; end
            default: begin p.i = LO_ZERO; p.q = LO_POS;  end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/quad_downmixer_if.sv
// Sample input and decimated I/Q output of the down-mixer.
//   in_valid/in_data/sync : sample source -> mixer (no backpressure)
//   out_valid/out_ready   : output handshake
//   out_i/out_q           : decimated pair, overrun: sticky overwrite flag
interface quad_downmixer_if;
    import quad_downmixer_pkg::*;

    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] in_data;
    logic                       sync;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [SAMPLE_W-1:0] out_i;
    logic signed [SAMPLE_W-1:0] out_q;
    logic                       overrun;

    modport slave (
        input  in_valid, in_data, sync, out_ready,
        output out_valid, out_i, out_q, overrun
    );

    modport master (
        output in_valid, in_data, sync, out_ready,
        input  out_valid, out_i, out_q, overrun
    );

endinterface

// File: rtl/quad_downmixer_lo_term.sv
// Multiplies a sign-extended sample by one LO rail code (+1, -1 or 0).
//   code : LO code for this rail
//   x    : sample, already sign-extended to W bits
//   term : selected product
module lo_term
    import quad_downmixer_pkg::*;
#(
    parameter int W = 19
) (
    input  lo_code_t           code,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] term
);

    always_comb begin
        term = '0;
        case (code)
            LO_POS:  term = x;
            LO_NEG:  term = -x;
            default: term = '0;
        endcase
    end

endmodule

// File: rtl/quad_downmixer.sv
// fs/4 quadrature down-mixer with integrate-and-dump decimation by DECIM.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : sample input and I/Q output handshake (slave side)
//
// state | meaning
// ACCUM | summing accepted samples, counter below DECIM-1
// DUMP  | last sample of the block: result loaded, sums and counter cleared
module quad_downmixer
    import quad_downmixer_pkg::*;
#(
    parameter int DECIM     = 16,
    parameter int LOG_DECIM = $clog2(DECIM)
) (
    input  logic              clk,
    input  logic              rst,
    quad_downmixer_if.slave   bus
);

    localparam int ACC_W = SAMPLE_W + LOG_DECIM;
    localparam logic [LOG_DECIM-1:0] CNT_LAST = LOG_DECIM'(DECIM - 1);

    logic [1:0]              phase;
    logic [LOG_DECIM-1:0]    cnt;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [ACC_W-1:0] ext, term_i, term_q;
    logic signed [ACC_W-1:0] sum_i, sum_q, shr_i, shr_q;
    lo_pair_t                lo;
    logic                    accept, dump;

    logic                       out_valid_r, overrun_r;
    logic signed [SAMPLE_W-1:0] out_i_r, out_q_r;

    assign lo     = phase_lo(phase);
    // widen before negation so -16384 maps to +16384
    assign ext    = {{LOG_DECIM{bus.in_data[SAMPLE_W-1]}}, bus.in_data};
    assign accept = bus.in_valid && !bus.sync;
    assign dump   = accept && (cnt == CNT_LAST);

    lo_term #(.W(ACC_W)) u_term_i (.code(lo.i), .x(ext), .term(term_i));
    lo_term #(.W(ACC_W)) u_term_q (.code(lo.q), .x(ext), .term(term_q));

    assign sum_i = acc_i + term_i;
    assign sum_q = acc_q + term_q;
    // only DECIM/2 samples per rail are nonzero, hence the LOG_DECIM-1 shift
    assign shr_i = sum_i >>> (LOG_DECIM - 1);
    assign shr_q = sum_q >>> (LOG_DECIM - 1);

    // upper bits are always copies of the sign by range
    logic unused_hi;
    assign unused_hi = ^{shr_i[ACC_W-1:SAMPLE_W], shr_q[ACC_W-1:SAMPLE_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            cnt         <= '0;
            acc_i       <= '0;
            acc_q       <= '0;
            out_valid_r <= 1'b0;
            out_i_r     <= '0;
            out_q_r     <= '0;
            overrun_r   <= 1'b0;
        end else begin
            if (bus.sync) begin
                phase <= '0;
                cnt   <= '0;
                acc_i <= '0;
                acc_q <= '0;
            end else if (bus.in_valid) begin
                phase <= phase + 2'd1;
                if (dump) begin
                    cnt   <= '0;
                    acc_i <= '0;
                    acc_q <= '0;
                end else begin
                    cnt   <= cnt + LOG_DECIM'(1);
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end

            if (dump) begin
                out_i_r     <= shr_i[SAMPLE_W-1:0];
                out_q_r     <= shr_q[SAMPLE_W-1:0];
                out_valid_r <= 1'b1;
                if (out_valid_r && !bus.out_ready)
                    overrun_r <= 1'b1;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_i     = out_i_r;
    assign bus.out_q     = out_q_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_quad_downmixer.sv
module tb_quad_downmixer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    quad_downmixer_if bus ();

    quad_downmixer #(.DECIM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef logic [3:0][14:0] blk_t;

    typedef struct {
        blk_t d;
        int   exp_i;
        int   exp_q;
    } vec_t;

    int total = 0;
    int bad   = 0;

    vec_t vecs [9];

    function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                                input int ei, input int eq);
        vec_t v;
        v.d[0] = s0[14:0];
        v.d[1] = s1[14:0];
        v.d[2] = s2[14:0];
        v.d[3] = s3[14:0];
        v.exp_i = ei;
        v.exp_q = eq;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_block(input blk_t d, input int max_gap, input bit rdy_last);
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = d[k];
            if (rdy_last && k == 3) bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (rdy_last) bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.sync = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_one(input int s);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = s[14:0];
    endtask

    vec_t cos1000, sin1000, cos500;

    initial begin
        cos1000 = mk(1000, 0, -1000, 0, 1000, 0);
        sin1000 = mk(0, 1000, 0, -1000, 0, -1000);
        cos500  = mk(500, 0, -500, 0, 500, 0);

        vecs[0] = cos1000;
        vecs[1] = sin1000;
        vecs[2] = mk(16383, 0, -16384, 0, 16383, 0);
        vecs[3] = mk(-16384, 0, 16383, 0, -16384, 0);
        vecs[4] = mk(100, 100, 100, 100, 0, 0);
        vecs[5] = mk(7, 3, -5, 9, 6, 3);
        vecs[6] = mk(1, 0, 0, 0, 0, 0);
        vecs[7] = mk(-1, 0, 0, 0, -1, 0);
        vecs[8] = mk(0, 1, 0, 0, 0, -1);

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sync      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_i", int'(bus.out_i), 0);
        check("reset out_q", int'(bus.out_q), 0);
        check("reset overrun", int'(bus.overrun), 0);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_block(vecs[v].d, 0, 1'b0);
            check($sformatf("vec%0d out_valid", v), int'(bus.out_valid), 1);
            check($sformatf("vec%0d out_i", v), int'(bus.out_i), vecs[v].exp_i);
            check($sformatf("vec%0d out_q", v), int'(bus.out_q), vecs[v].exp_q);
            @(negedge clk);
            check($sformatf("vec%0d pulse end", v), int'(bus.out_valid), 0);
        end

        for (int r = 0; r < 3; r++) begin
            run_block(sin1000.d, 3, 1'b0);
            check($sformatf("gap sine%0d out_i", r), int'(bus.out_i), 0);
            check($sformatf("gap sine%0d out_q", r), int'(bus.out_q), -1000);
            run_block(cos1000.d, 2, 1'b0);
            check($sformatf("gap cos%0d out_i", r), int'(bus.out_i), 1000);
            check($sformatf("gap cos%0d out_q", r), int'(bus.out_q), 0);
        end
        check("no overrun after stream", int'(bus.overrun), 0);

        // backpressure across two blocks
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_block(cos1000.d, 0, 1'b0);
        check("bp first valid", int'(bus.out_valid), 1);
        check("bp first out_i", int'(bus.out_i), 1000);
        repeat (3) @(negedge clk);
        check("bp hold valid", int'(bus.out_valid), 1);
        check("bp hold out_i", int'(bus.out_i), 1000);
        check("bp hold overrun", int'(bus.overrun), 0);
        run_block(sin1000.d, 1, 1'b0);
        check("bp second out_i", int'(bus.out_i), 0);
        check("bp second out_q", int'(bus.out_q), -1000);
        check("bp overrun set", int'(bus.overrun), 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp drained", int'(bus.out_valid), 0);
        check("bp overrun sticky", int'(bus.overrun), 1);

        // handshake coincident with the second dump
        do_reset();
        check("rst clears overrun", int'(bus.overrun), 0);
        bus.out_ready = 1'b0;
        run_block(cos1000.d, 0, 1'b0);
        run_block(sin1000.d, 0, 1'b1);
        check("pulse valid continuous", int'(bus.out_valid), 1);
        check("pulse new out_q", int'(bus.out_q), -1000);
        check("pulse no overrun", int'(bus.overrun), 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("pulse drained", int'(bus.out_valid), 0);

        // sync mid-block with a pending pair
        bus.out_ready = 1'b0;
        run_block(cos1000.d, 0, 1'b0);
        send_one(300);
        send_one(200);
        @(negedge clk);
        bus.sync     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 15'sd7777;
        @(negedge clk);
        bus.sync     = 1'b0;
        bus.in_valid = 1'b0;
        check("sync pending valid", int'(bus.out_valid), 1);
        check("sync pending out_i", int'(bus.out_i), 1000);
        check("sync no overrun", int'(bus.overrun), 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("sync drained", int'(bus.out_valid), 0);
        run_block(cos500.d, 0, 1'b0);
        check("post sync valid", int'(bus.out_valid), 1);
        check("post sync out_i", int'(bus.out_i), 500);
        check("post sync out_q", int'(bus.out_q), 0);

        // reset mid-block and mid-pending
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_block(sin1000.d, 0, 1'b0);
        run_block(cos1000.d, 0, 1'b0);
        send_one(300);
        send_one(200);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst out_valid", int'(bus.out_valid), 0);
        check("mid rst out_i", int'(bus.out_i), 0);
        check("mid rst out_q", int'(bus.out_q), 0);
        check("mid rst overrun", int'(bus.overrun), 0);
        bus.out_ready = 1'b1;
        run_block(cos500.d, 0, 1'b0);
        check("post rst valid", int'(bus.out_valid), 1);
        check("post rst out_i", int'(bus.out_i), 500);
        check("post rst out_q", int'(bus.out_q), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
